// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx transmitter between
// up to four byte requesters. One byte is granted at a time. The next grant
// waits until the transmitter has gone busy and returned idle. A byte with
// req_last=0 locks the arbiter to its requester until that packet ends. A
// stalled lock is released after LOCK_TIMEOUT idle cycles.
module uart_tx_arb #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int IDW          = (NUM_REQ > 2) ? 2 : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 locked,
  output logic                 lock_timeout_evt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [9:0] TIMEOUT_C = 10'(LOCK_TIMEOUT);

  state_t         state_r;
  logic           tx_en_r;
  logic [7:0]     tx_data_r;
  logic [IDW-1:0] grant_id_r;   // doubles as the round-robin pointer
  logic [IDW-1:0] lock_id_r;
  logic           locked_r;
  logic           evt_r;
  logic [9:0]     cnt_r;

  logic [IDW-1:0] pick_s;
  logic           found_s;
  logic           grant_s;
  logic [7:0]     pick_data_s;
  logic           lock_valid_s;
  logic           cnt_inc_s;
  logic           to_hit_s;

  // Round-robin search starting one past the last grant, restricted to the
  // lock owner while a packet lock is active.
  always_comb begin
    int   idx;
    logic hit;
    found_s = 1'b0;
    pick_s  = {IDW{1'b0}};
    idx     = 0;
    hit     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(grant_id_r) + k;
      idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      hit = req_valid[idx] && (!locked_r || (lock_id_r == IDW'(idx)));
      pick_s  = (!found_s && hit) ? IDW'(idx) : pick_s;
      found_s = found_s | hit;
    end
  end

  assign grant_s      = (state_r == ST_IDLE) && enable && found_s;
  assign pick_data_s  = req_data[{pick_s, 3'b000} +: 8];
  assign lock_valid_s = req_valid[lock_id_r];

  // The timeout only runs while the locked owner is absent. A grant in the
  // same cycle the count is reached takes priority over the release.
  assign cnt_inc_s = locked_r && enable && (TIMEOUT_C != 10'd0) && !lock_valid_s;
  assign to_hit_s  = locked_r && enable && (TIMEOUT_C != 10'd0) &&
                     (cnt_r == TIMEOUT_C) && !grant_s;

  // One-hot ready toward the granted requester, only in the grant cycle.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_s && (pick_s == IDW'(i));
    end
  end

  // Sequencer FSM with registered transmitter strobe, lock and timeout state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      tx_en_r    <= 1'b0;
      tx_data_r  <= 8'h00;
      grant_id_r <= IDW'(NUM_REQ - 1);
      lock_id_r  <= {IDW{1'b0}};
      locked_r   <= 1'b0;
      evt_r      <= 1'b0;
      cnt_r      <= 10'd0;
    end else begin
      evt_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            tx_data_r  <= pick_data_s;
            grant_id_r <= pick_s;
            lock_id_r  <= pick_s;
            locked_r   <= !req_last[pick_s];
            cnt_r      <= 10'd0;
            tx_en_r    <= 1'b1;
            state_r    <= ST_SEND;
          end else if (to_hit_s) begin
            locked_r <= 1'b0;
            cnt_r    <= 10'd0;
            evt_r    <= 1'b1;
            tx_en_r  <= 1'b0;
          end else if (!locked_r) begin
            cnt_r   <= 10'd0;
            tx_en_r <= 1'b0;
          end else if (cnt_inc_s) begin
            cnt_r   <= cnt_r + 10'd1;
            tx_en_r <= 1'b0;
          end else begin
            cnt_r   <= cnt_r;
            tx_en_r <= 1'b0;
          end
        end
        ST_SEND: begin
          tx_en_r <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          tx_en_r <= 1'b0;
          if (!tx_busy) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          tx_en_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_en            = tx_en_r;
  assign tx_data          = tx_data_r;
  assign grant_id         = grant_id_r;
  assign locked           = locked_r;
  assign lock_timeout_evt = evt_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: stimulus pushes expected grants into a
// queue and a negedge monitor pops and compares on every tx_en pulse.
module tb_uart_tx_arb;
  localparam int NR    = 2;
  localparam int FRAME = 6;

  typedef struct packed {
    logic [0:0] id;
    logic [7:0] data;
    logic       lk;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [0:0]    grant_id;
  logic          locked;
  logic          lock_timeout_evt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_cnt0 = 0;
  int tx_cnt = 0;
  int evt_cnt = 0;
  int last_busy_cyc = 0;
  int bcnt = 0;
  logic en_s;
  logic [NR-1:0] fire;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(2), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked),
    .lock_timeout_evt(lock_timeout_evt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_b(input logic [0:0] id, input logic [7:0] data, input logic lk);
    exp_t e;
    e.id = id; e.data = data; e.lk = lk;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    while (n < maxc && !(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
                         tx_busy == 1'b0 && tx_en == 1'b0)) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL %s drain timeout: pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic wait_busy(input string name, input int maxc);
    int n;
    n = 0;
    while (n < maxc && !tx_busy) begin
      @(posedge clk); #2;
      n++;
    end
    total++;
    if (n >= maxc) begin
      bad++;
      $display("FAIL %s busy wait timeout: busy=%0b required=1", name, tx_busy);
    end
  endtask

  // Requester model: each queue head is presented; popped after a handshake.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready & {NR{resetn}};
      @(posedge clk); #1;
      if (fire[0]) void'(q0.pop_front());
      if (fire[1]) void'(q1.pop_front());
      req_valid[0]     = (q0.size() > 0);
      req_data[7:0]    = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_last[0]      = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_valid[1]     = (q1.size() > 0);
      req_data[15:8]   = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_last[1]      = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  // Transmitter model: busy rises the cycle after tx_en, lasts FRAME cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      en_s = tx_en;
      @(posedge clk); #1;
      if (!resetn) begin
        tx_busy = 1'b0; bcnt = 0;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end else if (en_s) begin
        tx_busy = 1'b1; bcnt = FRAME;
      end
    end
  end

  // Monitor: compares each transmitted byte against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (tx_busy) last_busy_cyc = cyc;
        if (req_ready[0]) ready_cnt0++;
        if (req_ready != 2'b00) chk("ready_onehot", {31'b0, $onehot(req_ready)}, 32'd1);
        if (tx_en) begin
          tx_cnt++;
          chk("tx_en_while_busy", {31'b0, tx_busy}, 32'd0);
          chk("ready_in_send", {30'b0, req_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx actual data=%0h id=%0d required none", tx_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", {24'b0, tx_data}, {24'b0, e.data});
            chk("grant_id", {31'b0, grant_id}, {31'b0, e.id});
            chk("locked_at_send", {31'b0, locked}, {31'b0, e.lk});
          end
        end
        if (lock_timeout_evt) begin
          evt_cnt++;
          chk("evt_gap", cyc - last_busy_cyc, 32'd11);
          chk("evt_ready", {30'b0, req_ready}, 32'd1);
          chk("evt_locked", {31'b0, locked}, 32'd0);
        end
      end
    end
  end

  initial begin
    int n0;
    resetn = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_tx_en", {31'b0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_grant_id", {31'b0, grant_id}, 32'd1);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_evt", {31'b0, lock_timeout_evt}, 32'd0);
    chk("rst_ready", {30'b0, req_ready}, 32'd0);

    // Single byte from requester 0.
    ready_cnt0 = 0;
    q0.push_back({1'b1, 8'h55});
    expect_b(1'b0, 8'h55, 1'b0);
    drain("t1", 200);
    chk("t1_ready_cycles", ready_cnt0, 32'd1);
    chk("t1_locked", {31'b0, locked}, 32'd0);

    // Both valid; pointer is at 0 so requester 1 leads, then alternate.
    q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h20}); q1.push_back({1'b1, 8'h21});
    expect_b(1'b1, 8'h20, 1'b0); expect_b(1'b0, 8'h10, 1'b0);
    expect_b(1'b1, 8'h21, 1'b0); expect_b(1'b0, 8'h11, 1'b0);
    drain("t2", 400);

    // Locked two-byte packet from requester 1 while requester 0 waits.
    q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b1, 8'hA2});
    q0.push_back({1'b1, 8'h30});
    expect_b(1'b1, 8'hA1, 1'b1); expect_b(1'b1, 8'hA2, 1'b0);
    expect_b(1'b0, 8'h30, 1'b0);
    drain("t3", 400);

    // Requester 1 opens a packet and stalls; the lock times out.
    evt_cnt = 0;
    q1.push_back({1'b0, 8'hB1});
    q0.push_back({1'b1, 8'h40});
    expect_b(1'b1, 8'hB1, 1'b1); expect_b(1'b0, 8'h40, 1'b0);
    drain("t4", 400);
    chk("t4_evt_count", evt_cnt, 32'd1);
    chk("t4_locked", {31'b0, locked}, 32'd0);

    // Disable during WAIT: current byte completes, nothing else until re-enable.
    n0 = tx_cnt;
    q1.push_back({1'b1, 8'h60}); q1.push_back({1'b1, 8'h61});
    q0.push_back({1'b1, 8'h50});
    expect_b(1'b1, 8'h60, 1'b0);
    wait_busy("t5", 100);
    enable = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("t5_held_tx", tx_cnt - n0, 32'd1);
    chk("t5_queue_held", q0.size() + q1.size(), 32'd2);
    expect_b(1'b0, 8'h50, 1'b0); expect_b(1'b1, 8'h61, 1'b0);
    enable = 1'b1;
    drain("t5", 400);

    // Reset mid-frame while a lock is held.
    q1.push_back({1'b0, 8'hC1});
    expect_b(1'b1, 8'hC1, 1'b1);
    wait_busy("t6", 100);
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_tx_en", {31'b0, tx_en}, 32'd0);
    chk("mid_rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("mid_rst_grant_id", {31'b0, grant_id}, 32'd1);
    chk("mid_rst_locked", {31'b0, locked}, 32'd0);
    chk("mid_rst_evt", {31'b0, lock_timeout_evt}, 32'd0);
    chk("mid_rst_ready", {30'b0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    q0.push_back({1'b1, 8'h70}); q1.push_back({1'b1, 8'h71});
    expect_b(1'b0, 8'h70, 1'b0); expect_b(1'b1, 8'h71, 1'b0);
    drain("t6", 400);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
